fifo_read_arbiter: RTL
======================

FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters sharing one FIFO read port.
REQ-002 SHALL have parameter BURST, default 4, meaning maximum reads per grant (1..15).
REQ-003 SHALL have parameter DW, default 8, meaning FIFO data width.
REQ-004 SHALL have port r_clk, input, 1 bit, the read-domain clock; all logic runs on its rising edge.
REQ-005 SHALL have port r_reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port req, input, NREQ bits, per-requester read request (level).
REQ-007 SHALL have port empty, input, 1 bit, FIFO empty flag from the read handler.
REQ-008 SHALL have port rdata, input, DW bits, FIFO read data, valid the cycle after r_en.
REQ-009 SHALL have port r_en, output, 1 bit, FIFO read enable.
REQ-010 SHALL have port gnt, output, NREQ bits, registered one-hot grant.
REQ-011 SHALL have port dvalid, output, NREQ bits, registered one-hot data-valid tag.
REQ-012 SHALL have port dout, output, DW bits, carrying rdata to the tagged requester.
REQ-013 SHALL have port busy, output, 1 bit, high while state is READ.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and READ.
REQ-015 In IDLE with req nonzero, SHALL select the first asserted requester searching circularly from index (last+1) mod NREQ, then register gnt one-hot and enter READ next cycle.
REQ-016 In IDLE with req zero, SHALL hold gnt=0 and stay in IDLE.
REQ-017 In READ, SHALL drive r_en = !empty AND req[owner], combinationally; r_en SHALL be 0 in IDLE.
REQ-018 SHALL count beats with a 4-bit counter: cleared on grant and incremented on each cycle r_en=1.
REQ-019 In READ, SHALL return to IDLE after the cycle in which the BURST-th beat is issued, or in the first cycle req[owner]=0; gnt clears on that transition.
REQ-020 In READ with empty=1 and req[owner]=1, SHALL stall: r_en=0, counter holds, grant holds, with no timeout.
REQ-021 SHALL register dvalid one cycle after each r_en=1, equal to the owner one-hot at issue time, and 0 otherwise.
REQ-022 SHALL drive dout = rdata; dout is meaningful only while dvalid is nonzero.
REQ-023 SHALL update last to the owner index on each grant, so a released requester has lowest priority at the next arbitration.
REQ-024 SHALL leave one IDLE cycle between consecutive grants; no back-to-back regrant.
REQ-025 SHALL never assert more than one bit of gnt or dvalid.
REQ-026 Where the final beat and the owner's req drop coincide, SHALL count the beat and release once.
REQ-027 SHALL issue no r_en in the same cycle empty=1 (no underflow).

Reset
REQ-028 While r_reset=1, asynchronously: state=IDLE, gnt=0, dvalid=0, counter=0, last=NREQ-1 (so requester 0 wins first), busy=0, r_en=0.
REQ-029 A reset asserted mid-burst SHALL abort the burst; an r_en issued in the reset cycle produces no dvalid.
REQ-030 After reset deasserts, arbitration SHALL begin on the first rising edge with req nonzero.

Verification
REQ-031 Reset, then req=4'b0001 held, empty=0, BURST=4 -> gnt=0001 at cycle 1, r_en high cycles 1-4, dvalid=0001 cycles 2-5, IDLE at cycle 5.
REQ-032 req=4'b1111 held, empty=0 -> grant order 0,1,2,3,0, each 4 beats, one idle cycle between grants.
REQ-033 Owner 2 granted, empty=1 for 3 cycles after beat 1 -> r_en=0 and counter=1 held for those cycles, then 3 more beats issue, 4 total.
REQ-034 Owner 1 drops req after beat 2 -> release with 2 beats, dvalid=0010 exactly twice, and next grant goes to the first asserted index above 1.
REQ-035 r_reset pulse during beat 3 of owner 3 -> gnt, dvalid and busy = 0 immediately, and next grant goes to requester 0 if requesting.
REQ-036 Randomized req and empty over 10k cycles -> gnt and dvalid are one-hot-or-zero, r_en is never high with empty=1, and no requester waits more than NREQ*(BURST+1) non-empty cycles.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
// Shares one FIFO read port between NREQ requesters. A round-robin pick is
// made in IDLE; the winner owns the port for up to BURST beats, or until it
// drops its request. Read data returns one cycle after r_en, and dvalid tags
// it with the owner's one-hot.
module fifo_read_arbiter #(
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  parameter int DW    = 8
) (
  input  logic            r_clk,
  input  logic            r_reset,
  input  logic [NREQ-1:0] req,
  input  logic            empty,
  input  logic [DW-1:0]   rdata,
  output logic            r_en,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] dvalid,
  output logic [DW-1:0]   dout,
  output logic            busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, READ} state_t;

  state_t          state_reg, state_next;
  // last_reg is also the current owner while in READ.
  logic [IW-1:0]   last_reg, last_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] dvalid_reg, dvalid_next;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [NREQ-1:0] win_onehot;
  logic            owner_req;

  // One-hot form of the arbitration winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_win_onehot
    assign win_onehot[gi] = (win_idx == IW'(gi));
  end

  assign owner_req = req[last_reg];

  // Circular search for the first requester after the previous owner.
  always_comb begin
    int idx;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_reg) + i) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // Next-state, read-enable and data-valid decode.
  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    cnt_next    = cnt_reg;
    gnt_next    = gnt_reg;
    dvalid_next = '0;
    r_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (win_found) begin
          state_next = READ;
          last_next  = win_idx;
          cnt_next   = 4'd0;
          gnt_next   = win_onehot;
        end
      end
      READ: begin
        // Never read from an empty FIFO; a stalled owner keeps the grant.
        r_en = !empty && owner_req;
        if (r_en) begin
          cnt_next    = cnt_reg + 4'd1;
          dvalid_next = gnt_reg;
        end
        // A final beat coinciding with a request drop releases only once.
        if (!owner_req || (r_en && (cnt_reg == 4'(BURST - 1)))) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State registers; reset leaves requester 0 with top priority.
  always_ff @(posedge r_clk or posedge r_reset) begin
    if (r_reset) begin
      state_reg  <= IDLE;
      last_reg   <= IW'(NREQ - 1);
      cnt_reg    <= 4'd0;
      gnt_reg    <= '0;
      dvalid_reg <= '0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      cnt_reg    <= cnt_next;
      gnt_reg    <= gnt_next;
      dvalid_reg <= dvalid_next;
    end
  end

  assign gnt    = gnt_reg;
  assign dvalid = dvalid_reg;
  assign busy   = (state_reg == READ);
  assign dout   = rdata;

endmodule
